// File: rtl/frame_sequencer.sv
// frame_sequencer
// Frame-level controller for the interleaver -> QPSK mod -> channel -> QPSK
// demod -> deinterleaver loopback chain. A start/busy/done handshake drives
// one frame at a time: run the interleaver, stream the interleaved frame out
// as SYM_W-bit symbols (LSB symbol first), reassemble the demodulated symbols
// MOD_LAT cycles later, then run the deinterleaver. Waits on inter_eno and
// deinter_eno are bounded by TIMEOUT cycles; expiry produces an err pulse.
//
// Ports:
//   clk          in   system clock, all state on rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   request one frame (sampled only in IDLE)
//   busy         out  high in every state except IDLE
//   done         out  one-cycle pulse on successful completion
//   err          out  one-cycle pulse on timeout
//   inter_en     out  interleaver enable
//   inter_eno    in   interleaver result valid
//   inter_data   in   interleaved frame [FRAME_W]
//   mod_sym      out  symbol to modulator [SYM_W]
//   mod_vld      out  mod_sym is a live symbol
//   demod_sym    in   demodulator output [SYM_W]
//   deinter_en   out  deinterleaver enable
//   deinter_data out  reassembled received frame [FRAME_W]
//   deinter_eno  in   deinterleaver result valid
module frame_sequencer #(
  parameter int FRAME_W = 28,
  parameter int SYM_W   = 2,
  parameter int MOD_LAT = 3,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               inter_en,
  input  logic               inter_eno,
  input  logic [FRAME_W-1:0] inter_data,
  output logic [SYM_W-1:0]   mod_sym,
  output logic               mod_vld,
  input  logic [SYM_W-1:0]   demod_sym,
  output logic               deinter_en,
  output logic [FRAME_W-1:0] deinter_data,
  input  logic               deinter_eno
);

  localparam int NSYM = FRAME_W / SYM_W;
  localparam int CW   = $clog2(NSYM + MOD_LAT + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] C_NSYM = CW'(NSYM);
  localparam logic [CW-1:0] C_LAT  = CW'(MOD_LAT);
  localparam logic [CW-1:0] C_LAST = CW'(NSYM + MOD_LAT - 1);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ILV,
    S_STREAM,
    S_DEILV
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [TW-1:0]      tcnt_q, tcnt_d;
  logic [FRAME_W-1:0] tx_q, tx_d;
  logic [FRAME_W-1:0] rx_q, rx_d;
  logic [SYM_W-1:0]   sym_q, sym_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               tx_live;
  logic               rx_live;
  logic [CW-1:0]      rx_idx;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    sym_d   = sym_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    tx_live = (state_q == S_STREAM) && (cnt_q < C_NSYM);
    // The counter never exceeds C_LAST inside STREAM, so only the lower
    // bound of the receive window needs checking.
    rx_live = (state_q == S_STREAM) && (cnt_q >= C_LAT);
    rx_idx  = cnt_q - C_LAT;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_ILV;
      end
      S_ILV: begin
        if (inter_eno) begin
          tx_d    = inter_data;
          cnt_d   = '0;
          state_d = S_STREAM;
        end else if (tcnt_q == T_MAX) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_STREAM: begin
        cnt_d = cnt_q + 1'b1;
        // tx is consumed as a shift register: the live symbol is always
        // the low SYM_W bits, which gives LSB-symbol-first order.
        if (tx_live) begin
          tx_d  = tx_q >> SYM_W;
          sym_d = tx_q[SYM_W-1:0];
        end
        // Receive writes only touch their own slot so the previous frame's
        // remaining symbols stay visible until overwritten.
        if (rx_live) begin
          for (int k = 0; k < NSYM; k++) begin
            if (rx_idx == CW'(k)) rx_d[k*SYM_W +: SYM_W] = demod_sym;
          end
        end
        if (cnt_q == C_LAST) state_d = S_DEILV;
      end
      S_DEILV: begin
        if (deinter_eno) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (tcnt_q == T_MAX) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Timeout counter restarts on every state entry and only runs in the
    // two wait states.
    if (state_d != state_q) begin
      tcnt_d = '0;
    end else if ((state_q == S_ILV) || (state_q == S_DEILV)) begin
      tcnt_d = tcnt_q + 1'b1;
    end else begin
      tcnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      sym_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      sym_q   <= sym_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign inter_en     = (state_q == S_ILV);
  assign deinter_en   = (state_q == S_DEILV);
  assign mod_vld      = tx_live;
  // Outside the transmit window the last symbol sent is held.
  assign mod_sym      = tx_live ? tx_q[SYM_W-1:0] : sym_q;
  assign deinter_data = rx_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule
